// File: rtl/jts16_sdram_arb.sv
// Four-bank SDRAM request arbiter with blanking-gated auto-refresh, one command outstanding.
// Define JTS16_SDRAM_PRIO_EN for fixed priority (ba0 > ba1 > ba2 > ba3) instead of round-robin.
module jts16_sdram_arb #(
    parameter int unsigned AW       = 22,
    parameter int unsigned RFSH_CNT = 384,
    parameter int unsigned RFSH_MAX = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          refresh_en,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic          ba0_rd,
    input  logic          ba1_rd,
    input  logic          ba2_rd,
    input  logic          ba3_rd,
    input  logic          ba0_wr,
    input  logic [15:0]   ba0_din,
    input  logic [1:0]    ba0_din_m,
    output logic          ba0_ack,
    output logic          ba1_ack,
    output logic          ba2_ack,
    output logic          ba3_ack,
    output logic          ba0_rdy,
    output logic          ba1_rdy,
    output logic          ba2_rdy,
    output logic          ba3_rdy,
    output logic [AW-1:0] sd_addr,
    output logic [1:0]    sd_ba,
    output logic          sd_rd,
    output logic          sd_wr,
    output logic          sd_rfsh,
    output logic [15:0]   sd_din,
    output logic [1:0]    sd_din_m,
    input  logic          sd_ack,
    input  logic          sd_rdy
);

    localparam int unsigned   CW      = $clog2(RFSH_MAX + 1);
    localparam logic [CW-1:0] CNT_TH  = CW'(RFSH_CNT);
    localparam logic [CW-1:0] CNT_TOP = CW'(RFSH_MAX);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RFSH  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] rfsh_cnt;
    logic          rfsh_pend;
    logic          rfsh_go;
    logic [3:0]    ack;
    logic [3:0]    rdy;
    logic [3:0]    req;
    logic          gnt_any;
    logic [1:0]    gnt_idx;
    logic [AW-1:0] gnt_addr;

    assign req     = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
    // Past RFSH_MAX the blanking gate is bypassed so the SDRAM never loses data.
    assign rfsh_go = rfsh_pend && (refresh_en || rfsh_cnt == CNT_TOP);

`ifdef JTS16_SDRAM_PRIO_EN
    always_comb begin
        gnt_any = |req;
        gnt_idx = 2'd3;
        if (req[0])      gnt_idx = 2'd0;
        else if (req[1]) gnt_idx = 2'd1;
        else if (req[2]) gnt_idx = 2'd2;
    end
`else
    logic [1:0] ptr;

    // Search starts one past the last granted bank.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            if (!gnt_any && req[ptr + 2'(i)]) begin
                gnt_any = 1'b1;
                gnt_idx = ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (state == IDLE && !rfsh_go && gnt_any) begin
            ptr <= gnt_idx;
        end
    end
`endif

    always_comb begin
        unique case (gnt_idx)
            2'd0:    gnt_addr = ba0_addr;
            2'd1:    gnt_addr = ba1_addr;
            2'd2:    gnt_addr = ba2_addr;
            default: gnt_addr = ba3_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rfsh_cnt  <= '0;
            rfsh_pend <= 1'b0;
            ack       <= '0;
            rdy       <= '0;
            sd_addr   <= '0;
            sd_ba     <= 2'd0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            sd_rfsh   <= 1'b0;
            sd_din    <= 16'd0;
            sd_din_m  <= 2'd0;
        end else begin
            ack <= '0;
            rdy <= '0;
            if (rfsh_cnt != CNT_TOP) rfsh_cnt <= rfsh_cnt + 1'b1;
            if (rfsh_cnt >= CNT_TH) rfsh_pend <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (rfsh_go) begin
                        sd_rfsh <= 1'b1;
                        state   <= RFSH;
                    end else if (gnt_any) begin
                        sd_addr  <= gnt_addr;
                        sd_ba    <= gnt_idx;
                        sd_din   <= ba0_din;
                        sd_din_m <= ba0_din_m;
                        sd_wr    <= (gnt_idx == 2'd0) && ba0_wr;
                        sd_rd    <= !((gnt_idx == 2'd0) && ba0_wr);
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd_ack) begin
                        sd_rd      <= 1'b0;
                        sd_wr      <= 1'b0;
                        ack[sd_ba] <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (sd_rdy) begin
                        rdy[sd_ba] <= 1'b1;
                        state      <= IDLE;
                    end
                end
                RFSH: begin
                    if (sd_ack) begin
                        sd_rfsh   <= 1'b0;
                        rfsh_cnt  <= '0;
                        rfsh_pend <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack;
    assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy;

endmodule

// File: tb/tb_jts16_sdram_arb.sv
// Scoreboard bench for jts16_sdram_arb: a controller model answers commands, a monitor
// pops expected commands/acks/rdys as the DUT presents them.
module tb_jts16_sdram_arb;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst, refresh_en;
    logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
    logic          ba0_rd, ba1_rd, ba2_rd, ba3_rd, ba0_wr;
    logic [15:0]   ba0_din;
    logic [1:0]    ba0_din_m;
    logic          ba0_ack, ba1_ack, ba2_ack, ba3_ack;
    logic          ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
    logic [AW-1:0] sd_addr;
    logic [1:0]    sd_ba;
    logic          sd_rd, sd_wr, sd_rfsh;
    logic [15:0]   sd_din;
    logic [1:0]    sd_din_m;
    logic          sd_ack, sd_rdy;

    always #5 clk = ~clk;

    jts16_sdram_arb #(.AW(AW), .RFSH_CNT(16), .RFSH_MAX(1024)) dut (
        .clk(clk), .rst(rst), .refresh_en(refresh_en),
        .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba0_rd(ba0_rd), .ba1_rd(ba1_rd), .ba2_rd(ba2_rd), .ba3_rd(ba3_rd),
        .ba0_wr(ba0_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
        .ba0_ack(ba0_ack), .ba1_ack(ba1_ack), .ba2_ack(ba2_ack), .ba3_ack(ba3_ack),
        .ba0_rdy(ba0_rdy), .ba1_rdy(ba1_rdy), .ba2_rdy(ba2_rdy), .ba3_rdy(ba3_rdy),
        .sd_addr(sd_addr), .sd_ba(sd_ba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_rfsh(sd_rfsh),
        .sd_din(sd_din), .sd_din_m(sd_din_m), .sd_ack(sd_ack), .sd_rdy(sd_rdy)
    );

    typedef struct {
        logic [1:0]    bank;
        logic [AW-1:0] addr;
        logic          wr;
        logic [15:0]   din;
        logic [1:0]    mask;
    } cmd_t;

    cmd_t cmd_q[$];
    int   ack_q[$];
    int   rdy_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_dly = 0;
    int   rdy_dly = 0;
    logic man_rdy = 1'b0;
    logic rfsh_ok = 1'b0;
    logic prev_cmd = 1'b0;
    logic prev_rf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] bank, input logic [AW-1:0] addr, input logic wr,
                            input logic [15:0] din, input logic [1:0] mask, input logic with_rdy);
        cmd_t c;
        c.bank = bank; c.addr = addr; c.wr = wr; c.din = din; c.mask = mask;
        cmd_q.push_back(c);
        ack_q.push_back(int'(bank));
        if (with_rdy) rdy_q.push_back(int'(bank));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cmd(input int budget, input string name);
        int n = 0;
        while (cmd_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_cmd_timeout"}, 64'(cmd_q.size()), 64'd0);
    endtask

    task automatic wait_all(input int budget, input string name);
        int n = 0;
        while ((cmd_q.size() + ack_q.size() + rdy_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(cmd_q.size() + ack_q.size() + rdy_q.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({ba3_ack, ba2_ack, ba1_ack, ba0_ack, ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy,
                    sd_addr, sd_ba, sd_rd, sd_wr, sd_rfsh, sd_din, sd_din_m});
    endfunction

    // Controller model: acks ack_dly cycles after a command appears, rdy rdy_dly later.
    initial begin : ctrl
        int   ph;
        int   wn;
        logic rf;
        ph = 0; wn = 0; rf = 1'b0;
        sd_ack = 1'b0; sd_rdy = 1'b0;
        forever begin
            @(negedge clk);
            sd_ack = 1'b0;
            sd_rdy = man_rdy;
            if (rst) begin
                ph = 0;
                continue;
            end
            if (ph == 0 && (sd_rd || sd_wr || sd_rfsh)) begin
                ph = 1;
                rf = sd_rfsh;
                wn = sd_rfsh ? 0 : ack_dly;
            end
            if (ph == 1) begin
                if (wn == 0) begin
                    sd_ack = 1'b1;
                    ph = rf ? 0 : 2;
                    wn = rdy_dly;
                end else wn--;
            end else if (ph == 2) begin
                if (wn == 0) begin
                    sd_rdy = 1'b1;
                    ph = 0;
                end else wn--;
            end
        end
    end

    initial begin : monitor
        logic [3:0] ack_v, rdy_v;
        cmd_t       c;
        int         b;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cmd = 1'b0;
                prev_rf  = 1'b0;
                continue;
            end
            ack_v = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
            rdy_v = {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};
            chk("sd_cmd_exclusive", 64'($onehot0({sd_rd, sd_wr, sd_rfsh})), 64'd1);
            chk("ack_onehot0", 64'($onehot0(ack_v)), 64'd1);
            chk("rdy_onehot0", 64'($onehot0(rdy_v)), 64'd1);
            if ((sd_rd || sd_wr) && !prev_cmd) begin
                if (cmd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_cmd: got bank %0d addr %0h expected none", sd_ba, sd_addr);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_bank", 64'(sd_ba), 64'(c.bank));
                    chk("cmd_addr", 64'(sd_addr), 64'(c.addr));
                    chk("cmd_wr", 64'(sd_wr), 64'(c.wr));
                    chk("cmd_rd", 64'(sd_rd), 64'(!c.wr));
                    if (c.wr) begin
                        chk("cmd_din", 64'(sd_din), 64'(c.din));
                        chk("cmd_din_m", 64'(sd_din_m), 64'(c.mask));
                    end
                end
            end
            if (ack_v != 4'd0) begin
                if (ack_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ack: got %b expected none", ack_v);
                end else begin
                    b = ack_q.pop_front();
                    chk("ack_bank", 64'(ack_v), 64'(4'b0001 << b));
                end
            end
            if (rdy_v != 4'd0) begin
                if (rdy_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rdy: got %b expected none", rdy_v);
                end else begin
                    b = rdy_q.pop_front();
                    chk("rdy_bank", 64'(rdy_v), 64'(4'b0001 << b));
                end
            end
            if (sd_rfsh && !prev_rf && !rfsh_ok) begin
                checks++; failures++;
                $display("FAIL early_rfsh: got sd_rfsh 1 expected 0");
            end
            prev_cmd = sd_rd || sd_wr;
            prev_rf  = sd_rfsh;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int first;
        rst = 1'b1; refresh_en = 1'b0;
        ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
        ba0_rd = 0; ba1_rd = 0; ba2_rd = 0; ba3_rd = 0; ba0_wr = 0;
        ba0_din = 16'd0; ba0_din_m = 2'd0;

        // Single read with slow controller
        ack_dly = 2; rdy_dly = 3;
        do_reset();
        chk("reset_outputs", all_outs(), 64'd0);
        push_exp(2'd2, 22'h1234, 1'b0, 16'd0, 2'd0, 1'b1);
        ba2_addr = 22'h1234; ba2_rd = 1'b1;
        @(negedge clk);
        chk("read_latency_rd", 64'(sd_rd), 64'd1);
        chk("read_latency_ba", 64'(sd_ba), 64'd2);
        ba2_rd = 1'b0;
        wait_all(40, "single_read");

        // Writes, then write+read together
        ack_dly = 0; rdy_dly = 1;
        push_exp(2'd0, 22'h1000, 1'b1, 16'hBEEF, 2'b10, 1'b1);
        ba0_addr = 22'h1000; ba0_din = 16'hBEEF; ba0_din_m = 2'b10; ba0_wr = 1'b1;
        @(negedge clk);
        chk("write_latency", 64'(sd_wr), 64'd1);
        ba0_wr = 1'b0;
        wait_all(40, "write");
        push_exp(2'd0, 22'h2ABC, 1'b1, 16'h1234, 2'b01, 1'b1);
        ba0_addr = 22'h2ABC; ba0_din = 16'h1234; ba0_din_m = 2'b01;
        ba0_wr = 1'b1; ba0_rd = 1'b1;
        @(negedge clk);
        ba0_wr = 1'b0; ba0_rd = 1'b0;
        wait_all(40, "write_wins");

        // Round-robin, all banks requesting, immediate controller
        ack_dly = 0; rdy_dly = 0;
        do_reset();
        for (int k = 0; k < 16; k++) begin
`ifdef JTS16_SDRAM_PRIO_EN
            push_exp(2'd0, 22'h100, 1'b0, 16'd0, 2'd0, 1'b1);
`else
            push_exp(2'((k + 1) % 4), 22'(22'h100 + (k + 1) % 4), 1'b0, 16'd0, 2'd0, 1'b1);
`endif
        end
        ba0_addr = 22'h100; ba1_addr = 22'h101; ba2_addr = 22'h102; ba3_addr = 22'h103;
        ba0_rd = 1; ba1_rd = 1; ba2_rd = 1; ba3_rd = 1;
        wait_cmd(200, "round_robin");
        ba0_rd = 0; ba1_rd = 0; ba2_rd = 0; ba3_rd = 0;
        wait_all(40, "round_robin");

        // Refresh gated by refresh_en, beats a same-cycle request
        do_reset();
        repeat (100) @(negedge clk);
        push_exp(2'd1, 22'h0555, 1'b0, 16'd0, 2'd0, 1'b1);
        ba1_addr = 22'h0555;
        rfsh_ok = 1'b1; refresh_en = 1'b1; ba1_rd = 1'b1;
        @(negedge clk);
        chk("rfsh_after_en", 64'(sd_rfsh), 64'd1);
        chk("rfsh_beats_rd", 64'(sd_rd), 64'd0);
        wait_cmd(20, "rfsh_gate");
        ba1_rd = 1'b0;
        wait_all(20, "rfsh_gate");
        refresh_en = 1'b0;
        @(negedge clk);
        rfsh_ok = 1'b0;

        // Forced refresh: counter hits 1024 on cycle 1024, command is registered next cycle
        do_reset();
        rfsh_ok = 1'b1;
        first = -1;
        for (int n = 1; n <= 1100; n++) begin
            @(negedge clk);
            if (sd_rfsh && first < 0) first = n;
        end
        chk("forced_rfsh_cycle", 64'(first), 64'd1025);
        rfsh_ok = 1'b0;

        // Reset during WAIT abandons the access
        ack_dly = 0; rdy_dly = 20;
        do_reset();
        push_exp(2'd3, 22'h3A5A5, 1'b0, 16'd0, 2'd0, 1'b0);
        ba3_addr = 22'h3A5A5; ba3_rd = 1'b1;
        wait_cmd(20, "mid_reset");
        ba3_rd = 1'b0;
        wait_all(20, "mid_reset");
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        man_rdy = 1'b1;
        @(negedge clk);
        man_rdy = 1'b0;
        repeat (5) @(negedge clk);
        rdy_dly = 0;
`ifdef JTS16_SDRAM_PRIO_EN
        push_exp(2'd0, 22'h0AAA, 1'b0, 16'd0, 2'd0, 1'b1);
`else
        push_exp(2'd1, 22'h0BBB, 1'b0, 16'd0, 2'd0, 1'b1);
`endif
        ba0_addr = 22'h0AAA; ba1_addr = 22'h0BBB; ba0_rd = 1'b1; ba1_rd = 1'b1;
        @(negedge clk);
        chk("post_reset_latency", 64'(sd_rd), 64'd1);
        ba0_rd = 1'b0; ba1_rd = 1'b0;
        wait_all(40, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
